// File: rtl/ddout.sv
// MII transmit serializer: bytes enter a small ring FIFO and leave on txd_o
// low nibble first, with frame enable, underrun error and a fixed inter-frame gap.
module ddout #(
  parameter int DEPTH   = 4,
  parameter int IFG_NIB = 24
) (
  input  logic       txclk_i,
  input  logic       rst_n,
  input  logic       wr_i,
  input  logic [7:0] dat_i,
  input  logic       eof_i,
  input  logic       clr_i,
  output logic       rdy_o,
  output logic [3:0] txd_o,
  output logic       txen_o,
  output logic       txer_o,
  output logic       busy_o,
  output logic       unf_o,
  output logic       ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(IFG_NIB + 1);
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [GW-1:0] GAP_LD = GW'(IFG_NIB - 1);

  typedef enum logic [2:0] {IDLE, LO, HI, ERR, GAP} state_t;

  state_t          state;
  logic [8:0]      mem [DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [CW-1:0]   count, eof_cnt;
  logic [GW-1:0]   gap;
  logic [8:0]      hold;
  logic [8:0]      head;
  logic            pop, wr_ok, eof_inc, eof_dec;

  assign head    = mem[rp];
  assign rdy_o   = (count != FULL);
  assign busy_o  = (state != IDLE);
  assign wr_ok   = wr_i && ((count != FULL) || pop);
  assign eof_inc = wr_ok && eof_i;
  assign eof_dec = pop && head[8];

  // Pops are decided from registered state only, so outputs never see inputs combinationally.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = (count == FULL) || (eof_cnt != '0);
      HI:      pop = !hold[8] && (count != '0);
      ERR:     pop = (count != '0);
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge txclk_i) begin
    if (wr_ok) mem[wp] <= {eof_i, dat_i};
  end

  always_ff @(posedge txclk_i) begin
    if (!rst_n) begin
      state   <= IDLE;
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      eof_cnt <= '0;
      gap     <= '0;
      hold    <= '0;
      txd_o   <= '0;
      txen_o  <= 1'b0;
      txer_o  <= 1'b0;
      unf_o   <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (pop)   rp <= rp + 1'b1;

      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case ({eof_inc, eof_dec})
        2'b10:   eof_cnt <= eof_cnt + 1'b1;
        2'b01:   eof_cnt <= eof_cnt - 1'b1;
        default: eof_cnt <= eof_cnt;
      endcase

      // Clear first so a same-cycle set below wins.
      if (clr_i) begin
        unf_o <= 1'b0;
        ovf_o <= 1'b0;
      end
      if (wr_i && !wr_ok) ovf_o <= 1'b1;

      case (state)
        IDLE: begin
          if (pop) begin
            hold   <= head;
            txd_o  <= head[3:0];
            txen_o <= 1'b1;
            state  <= LO;
          end
        end
        LO: begin
          txd_o <= hold[7:4];
          state <= HI;
        end
        HI: begin
          if (hold[8]) begin
            txen_o <= 1'b0;
            txd_o  <= '0;
            gap    <= GAP_LD;
            state  <= GAP;
          end else if (count != '0) begin
            hold  <= head;
            txd_o <= head[3:0];
            state <= LO;
          end else begin
            txer_o <= 1'b1;
            txd_o  <= '0;
            unf_o  <= 1'b1;
            state  <= ERR;
          end
        end
        ERR: begin
          // Flush the rest of the broken frame up to and including its eof byte.
          if (pop && head[8]) begin
            txen_o <= 1'b0;
            txer_o <= 1'b0;
            gap    <= GAP_LD;
            state  <= GAP;
          end
        end
        GAP: begin
          if (gap == '0) state <= IDLE;
          else           gap   <= gap - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddout.sv
// Bench for ddout: a queue-level transmit model checked every cycle, plus
// literal nibble sequences and gap lengths for each directed scenario.
module tb_ddout;

  localparam int DEPTH = 4;
  localparam int IFG   = 24;

  logic       clk;
  logic       rst_n, wr_i, eof_i, clr_i;
  logic [7:0] dat_i;
  logic       rdy_o, txen_o, txer_o, busy_o, unf_o, ovf_o;
  logic [3:0] txd_o;

  ddout #(.DEPTH(DEPTH), .IFG_NIB(IFG)) dut (
    .txclk_i(clk), .rst_n(rst_n), .wr_i(wr_i), .dat_i(dat_i), .eof_i(eof_i),
    .clr_i(clr_i), .rdy_o(rdy_o), .txd_o(txd_o), .txen_o(txen_o),
    .txer_o(txer_o), .busy_o(busy_o), .unf_o(unf_o), .ovf_o(ovf_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 0;

  // scoreboard state
  logic [3:0] exp_q[$];
  logic [3:0] cap_q[$];
  int  lo_run = 0, hi_run = 0, last_gap = 0, last_hi = 0;
  bit  saw_txer = 0;

  // behavioural model: FIFO as a queue, frame progress as flags and a quiet-time budget
  logic [8:0] mq[$];
  logic [8:0] m_cur, pe;
  bit  m_act = 0, m_hi = 0, m_err = 0;
  int  m_quiet = 0;
  logic [3:0] e_txd = '0;
  logic e_txen = 0, e_txer = 0, e_unf = 0, e_ovf = 0, e_rdy = 1, e_busy = 0;

  always @(posedge clk) begin
    int  n_before;
    bit  popped, has_eof, set_unf;
    if (!rst_n) begin
      mq.delete();
      m_act = 0; m_hi = 0; m_err = 0; m_quiet = 0;
      e_txd = '0; e_txen = 0; e_txer = 0; e_unf = 0; e_ovf = 0;
    end else begin
      n_before = mq.size();
      popped = 0; set_unf = 0; has_eof = 0;
      foreach (mq[i]) if (mq[i][8]) has_eof = 1;
      if (m_err) begin
        if (n_before != 0) begin
          pe = mq.pop_front(); popped = 1;
          if (pe[8]) begin
            m_err = 0; m_act = 0; e_txen = 0; e_txer = 0; m_quiet = IFG;
          end
        end
      end else if (m_act && m_hi) begin
        e_txd = m_cur[7:4]; m_hi = 0;
      end else if (m_act) begin
        if (m_cur[8]) begin
          m_act = 0; e_txen = 0; e_txd = '0; m_quiet = IFG;
        end else if (n_before != 0) begin
          pe = mq.pop_front(); popped = 1;
          m_cur = pe; e_txd = pe[3:0]; m_hi = 1;
        end else begin
          e_txer = 1; e_txd = '0; set_unf = 1; m_err = 1;
        end
      end else if (m_quiet > 0) begin
        m_quiet--;
      end else if (n_before == DEPTH || has_eof) begin
        pe = mq.pop_front(); popped = 1;
        m_cur = pe; e_txd = pe[3:0]; e_txen = 1; m_act = 1; m_hi = 1;
      end
      if (clr_i) begin e_unf = 0; e_ovf = 0; end
      if (set_unf) e_unf = 1;
      if (wr_i) begin
        if (n_before < DEPTH || popped) mq.push_back({eof_i, dat_i});
        else e_ovf = 1;
      end
    end
    e_rdy  = (mq.size() != DEPTH);
    e_busy = m_act || m_err || (m_quiet > 0);
  end

  // per-cycle compare and capture, away from the active edge
  always @(negedge clk) begin
    logic [9:0] act, expv;
    if (chk_en) begin
      act  = {txd_o, txen_o, txer_o, busy_o, unf_o, ovf_o, rdy_o};
      expv = {e_txd, e_txen, e_txer, e_busy, e_unf, e_ovf, e_rdy};
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL cycle @%0t: got %b expected %b (txd,txen,txer,busy,unf,ovf,rdy)",
                    $time, act, expv);
      if (txen_o && !txer_o) cap_q.push_back(txd_o);
      if (txer_o) saw_txer = 1;
      if (txen_o) begin
        if (lo_run > 0) last_gap = lo_run;
        lo_run = 0; hi_run++;
      end else begin
        if (hi_run > 0) last_hi = hi_run;
        hi_run = 0; lo_run++;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic e);
    wr_i = 1'b1; dat_i = d; eof_i = e;
    tick();
    wr_i = 1'b0; eof_i = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  task automatic chk_cap(input string nm);
    chk({nm, "_len"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      chk($sformatf("%s_nib%0d", nm, i), cap_q[i], exp_q[i]);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; wr_i = 1'b0; eof_i = 1'b0; clr_i = 1'b0; dat_i = '0;
    tick();
    chk_en = 1;
    tick();
    rst_n = 1'b1;
    chk("rst_rdy", rdy_o, 1);
    chk("rst_txen", txen_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_flags", {unf_o, ovf_o, txer_o}, 0);

    // single frame
    cap_q.delete(); saw_txer = 0;
    wr(8'h5A, 0); wr(8'hC3, 1);
    repeat (35) tick();
    exp_q = '{4'hA, 4'h5, 4'h3, 4'hC};
    chk_cap("single");
    chk("single_txen_len", last_hi, 4);
    chk("single_gap_ge25", lo_run >= 25, 1);
    chk("single_txer", saw_txer, 0);

    // streaming with pointer wrap
    cap_q.delete();
    for (int i = 0; i < 10; i++) begin
      wr(8'(i), i == 9);
      tick();
    end
    repeat (40) tick();
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin exp_q.push_back(4'(i)); exp_q.push_back(4'h0); end
    chk_cap("stream");
    chk("stream_txen_len", last_hi, 20);
    chk("stream_txer", saw_txer, 0);
    chk("stream_ovf", ovf_o, 0);

    // overflow: refill while popping, then write into a full FIFO with no pop
    cap_q.delete();
    wr(8'h01, 0); wr(8'h02, 0); wr(8'h03, 0); wr(8'h04, 0);
    chk("ovf_full_rdy", rdy_o, 0);
    chk("ovf_no_flag_yet", ovf_o, 0);
    wr(8'h05, 0);
    chk("ovf_started", txen_o, 1);
    wr(8'h06, 0);
    chk("ovf_set", ovf_o, 1);
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    chk("ovf_cleared", ovf_o, 0);
    wr(8'h07, 1);
    repeat (40) tick();
    exp_q = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h3, 4'h0, 4'h4, 4'h0, 4'h5, 4'h0, 4'h7, 4'h0};
    chk_cap("ovf");
    chk("ovf_unf", unf_o, 0);

    // underrun
    cap_q.delete(); saw_txer = 0;
    wr(8'h11, 0); wr(8'h22, 0); wr(8'h33, 0); wr(8'h44, 0);
    repeat (20) tick();
    chk("unf_txer_held", {txen_o, txer_o}, 2'b11);
    wr(8'hFF, 1);
    repeat (40) tick();
    exp_q = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h4, 4'h4};
    chk_cap("unf");
    chk("unf_flag", unf_o, 1);
    chk("unf_saw_txer", saw_txer, 1);
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    chk("unf_cleared", unf_o, 0);

    // back-to-back one-byte frames
    cap_q.delete();
    wr(8'h12, 1); wr(8'h34, 1);
    repeat (45) tick();
    exp_q = '{4'h2, 4'h1, 4'h4, 4'h3};
    chk_cap("b2b");
    chk("b2b_gap", last_gap, 25);

    // reset during the third nibble
    cap_q.delete();
    wr(8'hAB, 0); wr(8'hCD, 1);
    n = 0;
    while (!txen_o && n < 10) begin tick(); n++; end
    chk("mr_start", txen_o, 1);
    tick(); tick();
    chk("mr_third_nib", txd_o, 4'hD);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("mr_txen", txen_o, 0);
    chk("mr_txd", txd_o, 0);
    chk("mr_busy", busy_o, 0);
    chk("mr_rdy", rdy_o, 1);
    cap_q.delete();
    wr(8'h77, 1);
    repeat (35) tick();
    exp_q = '{4'h7, 4'h7};
    chk_cap("mr_after");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
